// File: rtl/rf_pkg.sv
// rf_pkg: shared defaults and reset-value helper for the multiport register file
package rf_pkg;
    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;
    localparam int RF_NUM_RD = 2;

    function automatic int unsigned rf_reset_value(input int unsigned idx, input bit init_index);
        return init_index ? idx : 0;
    endfunction
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy bits for pending write-backs, set wins over clear
module rf_scoreboard import rf_pkg::*; #(
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    waddr,
    input  logic                 rsv_en,
    input  logic [ADDR_W-1:0]    rsv_addr,
    output logic [2**ADDR_W-1:0] busy_nxt,
    output logic                 any_busy
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] busy, set_v, clr_v, zmask;

    always_comb begin
        set_v    = rsv_en ? DEPTH'(1) << rsv_addr : '0;
        clr_v    = we ? DEPTH'(1) << waddr : '0;
        zmask    = (ZERO_REG != 0) ? ~DEPTH'(1) : '1;
        // a same-cycle reservation belongs to a newer instruction, so it survives the clear
        busy_nxt = ((busy & ~clr_v) | set_v) & zmask;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= '0;
            any_busy <= 1'b0;
        end else begin
            busy     <= busy_nxt;
            any_busy <= |busy_nxt;
        end
    end
endmodule

// File: rtl/rf_multiport.sv
// rf_multiport: register file with one write port, NUM_RD bypassed registered read ports and busy scoreboard
module rf_multiport import rf_pkg::*; #(
    parameter int DATA_W     = RF_DATA_W,
    parameter int ADDR_W     = RF_ADDR_W,
    parameter int NUM_RD     = RF_NUM_RD,
    parameter int ZERO_REG   = 1,
    parameter int INIT_INDEX = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic                     any_busy
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy_nxt;
    logic              wr_ok;

    assign wr_ok = we && !(ZERO_REG != 0 && waddr == '0);

    rf_scoreboard #(.ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_sb (
        .clk(clk),
        .rst(rst),
        .we(we),
        .waddr(waddr),
        .rsv_en(rsv_en),
        .rsv_addr(rsv_addr),
        .busy_nxt(busy_nxt),
        .any_busy(any_busy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < DEPTH; j++)
                mem[j] <= DATA_W'(rf_reset_value(j, INIT_INDEX != 0));
        end else if (wr_ok) begin
            mem[waddr] <= wdata;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d, q;
        logic              b;
        always_comb begin
            a = raddr[p*ADDR_W +: ADDR_W];
            d = (ZERO_REG != 0 && a == '0) ? '0 : (wr_ok && waddr == a) ? wdata : mem[a];
        end
        always_ff @(posedge clk) begin
            if (rst) begin
                q <= '0;
                b <= 1'b0;
            end else if (rd_en[p]) begin
                q <= d;
                b <= busy_nxt[a];
            end
        end
        assign rdata[p*DATA_W +: DATA_W] = q;
        assign rd_busy[p] = b;
    end
endmodule

// File: tb/tb_rf_multiport.sv
// tb_rf_multiport: randomized and directed scoreboard bench for rf_multiport against an array model
module tb_rf_multiport;
    typedef struct {
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  b;
        logic        ab;
    } exp_t;

    logic        clk = 0;
    logic        rst = 0, we = 0, rsv_en = 0;
    logic [4:0]  waddr = 0, rsv_addr = 0;
    logic [31:0] wdata = 0;
    logic [1:0]  rd_en = 0;
    logic [9:0]  raddr = 0;
    logic [63:0] rdata;
    logic [1:0]  rd_busy;
    logic        any_busy;

    exp_t        q[$];
    exp_t        e;
    int          n_cmp = 0, n_bad = 0;

    logic [31:0] m_mem[32];
    bit          m_busy[32];
    logic [31:0] m_d[2];
    logic [1:0]  m_b;
    logic        m_ab;

    always #5 clk = ~clk;

    rf_multiport #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .INIT_INDEX(1)) dut (
        .clk(clk),
        .rst(rst),
        .we(we),
        .waddr(waddr),
        .wdata(wdata),
        .rsv_en(rsv_en),
        .rsv_addr(rsv_addr),
        .rd_en(rd_en),
        .raddr(raddr),
        .rdata(rdata),
        .rd_busy(rd_busy),
        .any_busy(any_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // drive one cycle of stimulus and record what the outputs must look like after the edge
    task automatic cyc(input bit r, input bit w, input int wa, input logic [31:0] wd,
                       input bit rv, input int ra, input bit [1:0] en, input int a0, input int a1);
        exp_t x;
        int   ad[2];
        @(negedge clk);
        rst = r; we = w; waddr = 5'(wa); wdata = wd; rsv_en = rv; rsv_addr = 5'(ra);
        rd_en = en; raddr = {5'(a1), 5'(a0)};
        ad[0] = a0 % 32;
        ad[1] = a1 % 32;
        if (r) begin
            for (int j = 0; j < 32; j++) begin
                m_mem[j] = j;
                m_busy[j] = 0;
            end
            m_d[0] = 0; m_d[1] = 0; m_b = 0; m_ab = 0;
        end else begin
            if (w && wa % 32 != 0) m_mem[wa % 32] = wd;
            if (w) m_busy[wa % 32] = 0;
            if (rv && ra % 32 != 0) m_busy[ra % 32] = 1;
            for (int p = 0; p < 2; p++)
                if (en[p]) begin
                    m_d[p] = (ad[p] == 0) ? 32'd0 : m_mem[ad[p]];
                    m_b[p] = (ad[p] == 0) ? 1'b0 : m_busy[ad[p]];
                end
            m_ab = 0;
            for (int j = 0; j < 32; j++) m_ab |= m_busy[j];
        end
        x.d0 = m_d[0]; x.d1 = m_d[1]; x.b = m_b; x.ab = m_ab;
        q.push_back(x);
    endtask

    task automatic rd(input bit [1:0] en, input int a0, input int a1);
        cyc(0, 0, 0, 0, 0, 0, en, a0, a1);
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("rdata0", rdata[31:0], e.d0);
            chk("rdata1", rdata[63:32], e.d1);
            chk("rd_busy", {30'd0, rd_busy}, {30'd0, e.b});
            chk("any_busy", {31'd0, any_busy}, {31'd0, e.ab});
        end
    end

    initial begin
        cyc(1, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        rd(2'b11, 7, 31);
        cyc(0, 1, 5, 32'hDEADBEEF, 0, 0, 2'b01, 5, 0);
        rd(2'b11, 5, 5);
        cyc(0, 1, 0, 32'h1234, 1, 0, 2'b11, 0, 0);
        rd(2'b11, 0, 0);
        cyc(0, 0, 0, 0, 1, 9, 2'b00, 0, 0);
        rd(2'b11, 9, 9);
        cyc(0, 1, 9, 32'h55, 0, 0, 2'b01, 9, 0);
        cyc(0, 1, 9, 32'hAA, 1, 9, 2'b10, 0, 9);
        rd(2'b01, 9, 0);
        rd(2'b10, 0, 3);
        for (int i = 0; i < 5; i++) cyc(0, 1, 3, 32'h3000 + i, 0, 0, 2'b00, 0, 3);
        rd(2'b10, 0, 3);
        cyc(0, 0, 0, 0, 1, 12, 2'b11, 12, 9);
        cyc(1, 1, 12, 32'hFFFF, 1, 12, 2'b11, 12, 12);
        rd(2'b11, 12, 9);
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 49) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom,
                1'($urandom_range(0, 1)), $urandom_range(0, 15), 2'($urandom_range(0, 3)),
                $urandom_range(0, 15), $urandom_range(0, 15));
        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
